// File: rtl/acq_trig_sequencer.sv
// ---------------------------------------------------------------------------
// acq_trig_sequencer
//   Sequences one acquisition around the qualified trigger:
//   PRE (pre-trigger fill) -> ARMED (wait for trigger edge or auto timeout)
//   -> POST (post-trigger fill) -> DONE (hold until readout acknowledges).
//   Drives the capture-buffer write enable and records the sample index at
//   which the trigger was accepted.
//
// Optional build macro:
//   ACQ_TRIG_TIMESTAMP_EN - adds trig_ts, a free-running 48-bit rxclk count
//                           captured on the accepted/forced trigger cycle.
//
// Ports:
//   rxclk, rst_n      sample clock, async active-low reset
//   start, stop       begin acquisition (IDLE only) / abort (highest priority)
//   single_mode       1: DONE -> IDLE on rd_ack, 0: DONE -> rearm
//   auto_mode         force a trigger after auto_timeout ARMED cycles
//   pre_num/post_num  samples written before arming / after trigger
//   auto_timeout      ARMED cycles before forced trigger (0 = never)
//   trig_in           qualified trigger level
//   rd_ack            readout done with the buffer (only seen in DONE)
//   wr_en             sample write enable (PRE, ARMED, POST)
//   trigged           trigger accepted, held until DONE is left
//   auto_trig         last trigger was forced by timeout
//   acq_done          high while in DONE
//   trig_pos          sample index of the accepted trigger
//   state_o           current state encoding
//   trig_ts           (macro only) timestamp of the accepted trigger
// ---------------------------------------------------------------------------
module acq_trig_sequencer #(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 3
) (
    input  logic               rxclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               single_mode,
    input  logic               auto_mode,
    input  logic [CNT_W-1:0]   pre_num,
    input  logic [CNT_W-1:0]   post_num,
    input  logic [CNT_W-1:0]   auto_timeout,
    input  logic               trig_in,
    input  logic               rd_ack,
    output logic               wr_en,
    output logic               trigged,
    output logic               auto_trig,
    output logic               acq_done,
    output logic [CNT_W-1:0]   trig_pos,
    output logic [STATE_W-1:0] state_o
`ifdef ACQ_TRIG_TIMESTAMP_EN
    ,
    output logic [47:0]        trig_ts
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state, state_nxt;
    logic             trig_prev;
    logic [CNT_W-1:0] pre_q, post_q, to_q;
    logic             single_q, auto_q;
    logic [CNT_W-1:0] idx;      // write-sample index
    logic [CNT_W-1:0] cnt;      // PRE/POST phase counter
    logic [CNT_W-1:0] to_cnt;   // ARMED cycle counter for auto trigger

    logic edge_det, auto_en, auto_fire, trig_acc;
    logic pre_hit, post_hit, cfg_load;

    assign wr_en    = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    assign acq_done = (state == S_DONE);
    assign state_o  = STATE_W'(state);

    always_comb begin
        edge_det  = trig_in & ~trig_prev;
        auto_en   = auto_q && (to_q != '0);
        auto_fire = (state == S_ARMED) && auto_en && (to_cnt == to_q - 1'b1);
        trig_acc  = (state == S_ARMED) && (edge_det || auto_fire);
        pre_hit   = (cnt == pre_q - 1'b1);
        post_hit  = (cnt == post_q - 1'b1);
        // Config is (re)latched on start from IDLE and on rearm out of DONE.
        cfg_load  = ((state == S_IDLE) && start) ||
                    ((state == S_DONE) && rd_ack && !single_q);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (pre_num == '0) ? S_ARMED : S_PRE;
            S_PRE:   if (pre_hit) state_nxt = S_ARMED;
            S_ARMED: if (trig_acc) state_nxt = (post_q == '0) ? S_DONE : S_POST;
            S_POST:  if (post_hit) state_nxt = S_DONE;
            S_DONE: begin
                if (rd_ack) begin
                    if (single_q) state_nxt = S_IDLE;
                    else          state_nxt = (pre_num == '0) ? S_ARMED : S_PRE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (stop) state_nxt = S_IDLE;
    end

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            trig_prev <= 1'b0;
            pre_q     <= '0;
            post_q    <= '0;
            to_q      <= '0;
            single_q  <= 1'b0;
            auto_q    <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            to_cnt    <= '0;
            trig_pos  <= '0;
            trigged   <= 1'b0;
            auto_trig <= 1'b0;
        end else begin
            trig_prev <= trig_in;   // edge history tracks in every state
            state     <= state_nxt;
            if (stop) begin
                trigged <= 1'b0;
            end else if (cfg_load) begin
                pre_q     <= pre_num;
                post_q    <= post_num;
                to_q      <= auto_timeout;
                single_q  <= single_mode;
                auto_q    <= auto_mode;
                idx       <= '0;
                cnt       <= '0;
                to_cnt    <= '0;
                trig_pos  <= '0;
                trigged   <= 1'b0;
                auto_trig <= 1'b0;
            end else begin
                if (wr_en) idx <= idx + 1'b1;

                if ((state == S_PRE && !pre_hit) || (state == S_POST && !post_hit))
                    cnt <= cnt + 1'b1;
                else
                    cnt <= '0;

                if (state != S_ARMED)
                    to_cnt <= '0;
                else if (auto_en)
                    to_cnt <= to_cnt + 1'b1;

                if (trig_acc) begin
                    trig_pos  <= idx;
                    trigged   <= 1'b1;
                    // a real edge on the timeout cycle wins over the forced one
                    auto_trig <= ~edge_det;
                end

                if ((state == S_DONE) && rd_ack) trigged <= 1'b0;
            end
        end
    end

`ifdef ACQ_TRIG_TIMESTAMP_EN
    logic [47:0] ts_cnt;

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt  <= '0;
            trig_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 48'd1;
            if (trig_acc && !stop) trig_ts <= ts_cnt;
        end
    end
`endif

endmodule
